itcm_loader: RTL and testbench

ITCM_LOADER -- requirements
Module: itcm_loader

---
 rtl/itcm_loader.sv | 135 +++++++++++++
 tb/tb_itcm_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/itcm_loader.sv
// Boot-time ITCM loader: packs a little-endian byte stream into ITCM words and
// holds the CPU in reset until the image is fully written.
module itcm_loader #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 2048,
    localparam int unsigned BYTES = DATA_W / 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              cpurst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BYTES-1:0]  mem_wstrb,
    output logic              core_hold,
    output logic              done,
    output logic              err,
    output logic [AW:0]       words_loaded
);

    localparam int unsigned LW = $clog2(BYTES);
    localparam int unsigned BW = AW + LW + 1;
    localparam int unsigned WW = AW + 1;
    localparam logic [BW-1:0] FULL = BW'(DEPTH * BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [BW-1:0]       byte_cnt_q, byte_cnt_d;
    logic [DATA_W-1:0]   buf_data_q, buf_data_d;
    logic [BYTES-1:0]    buf_strb_q, buf_strb_d;
    logic                we_q, we_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BYTES-1:0]    wstrb_q, wstrb_d;
    logic [WW-1:0]       words_q, words_d;

    logic [LW-1:0]       lane;
    logic [DATA_W-1:0]   fill_data;
    logic [BYTES-1:0]    fill_strb;

    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            buf_data_q <= '0;
            buf_strb_q <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            buf_data_q <= buf_data_d;
            buf_strb_q <= buf_strb_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            words_q    <= words_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        buf_data_d = buf_data_q;
        buf_strb_d = buf_strb_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        words_d    = words_q;

        // Buffer as it would look with the incoming byte merged into its lane.
        lane       = byte_cnt_q[LW-1:0];
        fill_data  = buf_data_q;
        fill_strb  = buf_strb_q;
        fill_data[{lane, 3'b000} +: 8] = in_byte;
        fill_strb[lane] = 1'b1;

        if (start) begin
            state_d    = S_LOAD;
            byte_cnt_d = '0;
            buf_data_d = '0;
            buf_strb_d = '0;
            words_d    = '0;
        end else if (state_q == S_LOAD && in_valid) begin
            if (byte_cnt_q == FULL) begin
                state_d = S_ERR;
            end else begin
                byte_cnt_d = byte_cnt_q + BW'(1);
                if ((&lane) || in_last) begin
                    // Completed word goes to the output registers; buffer restarts empty.
                    we_d       = 1'b1;
                    addr_d     = byte_cnt_q[AW+LW-1:LW];
                    wdata_d    = fill_data;
                    wstrb_d    = fill_strb;
                    words_d    = words_q + WW'(1);
                    buf_data_d = '0;
                    buf_strb_d = '0;
                end else begin
                    buf_data_d = fill_data;
                    buf_strb_d = fill_strb;
                end
                if (in_last) begin
                    state_d = S_DONE;
                end
            end
        end
    end

    assign in_ready     = (state_q == S_LOAD);
    assign done         = (state_q == S_DONE);
    assign err          = (state_q == S_ERR);
    assign core_hold    = (state_q != S_DONE);
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_wstrb    = wstrb_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_itcm_loader.sv
// Bench for itcm_loader: table-driven load scenarios on a 64-bit/16-word
// instance, hand-written start/reset corner cases, and a random-valid 32-bit run.
module tb_itcm_loader;

    logic clk = 1'b0;
    logic cpurst_n = 1'b0;
    always #5 clk = ~clk;

    // 64-bit instance
    logic        st64 = 0, v64 = 0, l64 = 0;
    logic [7:0]  b64 = '0;
    logic        rdy64, we64, hold64, done64, err64;
    logic [3:0]  addr64;
    logic [63:0] wdata64;
    logic [7:0]  wstrb64;
    logic [4:0]  words64;

    // 32-bit instance
    logic        st32 = 0, v32 = 0, l32 = 0;
    logic [7:0]  b32 = '0;
    logic        rdy32, we32, hold32, done32, err32;
    logic [3:0]  addr32;
    logic [31:0] wdata32;
    logic [3:0]  wstrb32;
    logic [4:0]  words32;

    itcm_loader #(.DATA_W(64), .DEPTH(16)) dut64 (
        .clk(clk), .cpurst_n(cpurst_n), .start(st64),
        .in_valid(v64), .in_byte(b64), .in_last(l64), .in_ready(rdy64),
        .mem_we(we64), .mem_addr(addr64), .mem_wdata(wdata64), .mem_wstrb(wstrb64),
        .core_hold(hold64), .done(done64), .err(err64), .words_loaded(words64)
    );

    itcm_loader #(.DATA_W(32), .DEPTH(16)) dut32 (
        .clk(clk), .cpurst_n(cpurst_n), .start(st32),
        .in_valid(v32), .in_byte(b32), .in_last(l32), .in_ready(rdy32),
        .mem_we(we32), .mem_addr(addr32), .mem_wdata(wdata32), .mem_wstrb(wstrb32),
        .core_hold(hold32), .done(done32), .err(err32), .words_loaded(words32)
    );

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] data;
        logic [15:0]  strb;
    } wr_t;

    typedef struct {
        int         n;
        logic [7:0] base;
        bit         last;
        int         exp_words;
        bit         exp_done;
        bit         exp_err;
    } scen_t;

    wr_t        wq64[$];
    wr_t        wq32[$];
    wr_t        expq[$];
    logic [7:0] sent[$];

    int n_chk  = 0;
    int n_fail = 0;

    always @(negedge clk) begin
        if (we64) wq64.push_back('{32'(addr64), 128'(wdata64), 16'(wstrb64)});
        if (we32) wq32.push_back('{32'(addr32), 128'(wdata32), 16'(wstrb32)});
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: byte j of the accepted stream lands in word j/nb, lane j%nb,
    // for the first 16*nb bytes only; anything beyond capacity is dropped.
    task automatic build_model(input int nb);
        int  keep;
        wr_t cur;
        keep = (sent.size() < 16 * nb) ? sent.size() : 16 * nb;
        expq.delete();
        cur = '{0, '0, '0};
        for (int j = 0; j < keep; j++) begin
            if (j % nb == 0) cur = '{32'(j / nb), '0, '0};
            cur.data[8 * (j % nb) +: 8] = sent[j];
            cur.strb[j % nb] = 1'b1;
            if (j % nb == nb - 1 || j == keep - 1) expq.push_back(cur);
        end
    endtask

    task automatic cmp_writes(input bit is32, input string tag);
        int  n;
        wr_t a;
        n = is32 ? wq32.size() : wq64.size();
        chk({tag, " write count"}, 128'(n), 128'(expq.size()));
        for (int i = 0; i < n && i < expq.size(); i++) begin
            a = is32 ? wq32[i] : wq64[i];
            chk($sformatf("%s w%0d addr", tag, i), 128'(a.addr), 128'(expq[i].addr));
            chk($sformatf("%s w%0d data", tag, i), a.data, expq[i].data);
            chk($sformatf("%s w%0d strb", tag, i), 128'(a.strb), 128'(expq[i].strb));
        end
    endtask

    task automatic pulse_start64();
        @(negedge clk); st64 = 1;
        @(negedge clk); st64 = 0;
        wq64.delete();
    endtask

    task automatic stream64(input int n, input logic [7:0] base, input bit last);
        sent.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            v64 = 1;
            b64 = base + 8'(i);
            l64 = last && (i == n - 1);
            sent.push_back(b64);
        end
        @(negedge clk);
        v64 = 0;
        l64 = 0;
    endtask

    task automatic chk_reset64(input string tag);
        chk({tag, " in_ready"}, 128'(rdy64), 0);
        chk({tag, " mem_we"}, 128'(we64), 0);
        chk({tag, " mem_addr"}, 128'(addr64), 0);
        chk({tag, " mem_wdata"}, 128'(wdata64), 0);
        chk({tag, " mem_wstrb"}, 128'(wstrb64), 0);
        chk({tag, " core_hold"}, 128'(hold64), 1);
        chk({tag, " done"}, 128'(done64), 0);
        chk({tag, " err"}, 128'(err64), 0);
        chk({tag, " words_loaded"}, 128'(words64), 0);
    endtask

    scen_t tbl[6];

    initial begin
        int    n;
        int    idx;
        string tag;

        tbl[0] = '{16,  8'h00, 1'b1, 2,  1'b1, 1'b0};
        tbl[1] = '{11,  8'hA0, 1'b1, 2,  1'b1, 1'b0};
        tbl[2] = '{129, 8'h00, 1'b0, 16, 1'b0, 1'b1};
        tbl[3] = '{1,   8'h5A, 1'b1, 1,  1'b1, 1'b0};
        tbl[4] = '{8,   8'h10, 1'b1, 1,  1'b1, 1'b0};
        tbl[5] = '{128, 8'h37, 1'b1, 16, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        chk_reset64("por");
        chk("por 32 core_hold", 128'(hold32), 1);
        cpurst_n = 1;
        repeat (2) @(negedge clk);
        chk("idle in_ready", 128'(rdy64), 0);

        for (int s = 0; s < 6; s++) begin
            tag = $sformatf("scen%0d", s);
            pulse_start64();
            chk({tag, " restart done"}, 128'(done64), 0);
            chk({tag, " restart err"}, 128'(err64), 0);
            chk({tag, " restart core_hold"}, 128'(hold64), 1);
            chk({tag, " restart words"}, 128'(words64), 0);
            chk({tag, " restart in_ready"}, 128'(rdy64), 1);
            stream64(tbl[s].n, tbl[s].base, tbl[s].last);
            chk({tag, " done"}, 128'(done64), 128'(tbl[s].exp_done));
            chk({tag, " err"}, 128'(err64), 128'(tbl[s].exp_err));
            chk({tag, " core_hold"}, 128'(hold64), 128'(!tbl[s].exp_done));
            chk({tag, " in_ready"}, 128'(rdy64), 0);
            chk({tag, " final mem_we"}, 128'(we64), 128'(tbl[s].exp_done));
            @(negedge clk);
            chk({tag, " mem_we drops"}, 128'(we64), 0);
            @(negedge clk);
            build_model(8);
            cmp_writes(1'b0, tag);
            chk({tag, " words_loaded"}, 128'(words64), 128'(tbl[s].exp_words));
            if (s == 0) begin
                chk("first word data", wq64.size() > 0 ? wq64[0].data : '1,
                    128'h0706050403020100);
                chk("second word data", wq64.size() > 1 ? wq64[1].data : '1,
                    128'h0F0E0D0C0B0A0908);
            end
            if (s == 1) begin
                chk("partial word data", wq64.size() > 1 ? wq64[1].data : '1,
                    128'h0000000000AAA9A8);
                chk("partial word strb", wq64.size() > 1 ? 128'(wq64[1].strb) : '1, 128'h07);
            end
        end

        // Start mid-word, colliding with a byte: both the partial word and that byte vanish.
        pulse_start64();
        stream64(3, 8'hC0, 1'b0);
        @(negedge clk); st64 = 1; v64 = 1; b64 = 8'hEE;
        @(negedge clk); st64 = 0; v64 = 0;
        chk("restart no write", 128'(wq64.size()), 0);
        chk("restart words", 128'(words64), 0);
        stream64(8, 8'h40, 1'b1);
        repeat (2) @(negedge clk);
        build_model(8);
        cmp_writes(1'b0, "restart");

        // Reset in the middle of a load.
        pulse_start64();
        stream64(5, 8'h60, 1'b0);
        cpurst_n = 0;
        #1;
        chk_reset64("midrst");
        @(negedge clk);
        cpurst_n = 1;
        v64 = 1; b64 = 8'h99; l64 = 1;
        repeat (3) @(negedge clk);
        chk("post-rst ignored in_ready", 128'(rdy64), 0);
        chk("post-rst ignored done", 128'(done64), 0);
        chk("post-rst no write", 128'(wq64.size()), 0);
        v64 = 0; l64 = 0;
        pulse_start64();
        stream64(16, 8'h00, 1'b1);
        chk("reload done", 128'(done64), 1);
        repeat (2) @(negedge clk);
        build_model(8);
        cmp_writes(1'b0, "reload");
        chk("reload words", 128'(words64), 2);

        // 32-bit instance with random gaps in in_valid.
        for (int r = 0; r < 4; r++) begin
            tag = $sformatf("rnd%0d", r);
            @(negedge clk); st32 = 1;
            @(negedge clk); st32 = 0;
            wq32.delete();
            sent.delete();
            n = (r == 0) ? 64 : $urandom_range(1, 60);
            idx = 0;
            while (idx < n) begin
                @(negedge clk);
                if ($urandom % 2 == 1) begin
                    v32 = 1;
                    b32 = 8'($urandom);
                    l32 = (idx == n - 1);
                    sent.push_back(b32);
                    idx++;
                end else begin
                    v32 = 0;
                    l32 = 0;
                end
            end
            @(negedge clk);
            v32 = 0;
            l32 = 0;
            chk({tag, " done"}, 128'(done32), 1);
            chk({tag, " final mem_we"}, 128'(we32), 1);
            repeat (2) @(negedge clk);
            build_model(4);
            cmp_writes(1'b1, tag);
            chk({tag, " words"}, 128'(words32), 128'((n + 3) / 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
